ptr_writeback_queue: RTL and testbench

- Write-side front end for the pointer register file: buffers pointer writes (target register, label id, offset) from the execute stage.
- Drains one write per cycle onto the file's we/pw/lbidw/ofsw port.
- Avoids colliding with p0 reads, because the file's shared p0/pw address port is taken by a write whenever we is high.
- Decodes writes to P3F into a jump pulse and flushes younger writes behind a jump.

---
 rtl/ptr_pkg.sv | 34 +++
 rtl/ptr_wr_fifo.sv | 82 ++++++++
 rtl/ptr_writeback_queue.sv | 144 ++++++++++++++
 tb/tb_ptr_writeback_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ptr_pkg.sv
// ----------------------------------------------------------------------------
// ptr_pkg
// Shared types and constants for the pointer register file write path.
//   PREG_AW  : pointer register address width
//   LBID_W   : label id width
//   OFS_W    : offset width
//   PC_PREG  : pointer register whose write means "jump"
//   ptr_wr_t : one buffered pointer write {p, lbid, ofs}
// ----------------------------------------------------------------------------
package ptr_pkg;

    localparam int PREG_AW = 6;
    localparam int LBID_W  = 12;
    localparam int OFS_W   = 16;

    localparam logic [PREG_AW-1:0] PC_PREG = 6'h3F;

    typedef struct packed {
        logic [PREG_AW-1:0] p;
        logic [LBID_W-1:0]  lbid;
        logic [OFS_W-1:0]   ofs;
    } ptr_wr_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } wbq_state_e;

    // A write to the program-counter pointer redirects the fetch stream.
    function automatic logic is_jump(input ptr_wr_t e);
        return e.p == PC_PREG;
    endfunction

endpackage

// File: rtl/ptr_wr_fifo.sv
// ----------------------------------------------------------------------------
// ptr_wr_fifo
// Circular buffer of pending pointer writes.
//   clk, reset     : clock, asynchronous active-high reset
//   push/push_data : append an entry (caller guarantees room or a same-edge pop)
//   pop            : drop the head entry
//   flush          : discard every entry, including a same-edge push
//   head           : oldest entry (valid when !empty)
//   count          : number of entries, 0..DEPTH
//   full, empty    : count==DEPTH, count==0
//   entry_valid    : per-slot occupancy, indexed by physical slot
//   entries        : raw slot contents, indexed by physical slot
// ----------------------------------------------------------------------------
module ptr_wr_fifo
    import ptr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  ptr_wr_t                    push_data,
    input  logic                       pop,
    input  logic                       flush,
    output ptr_wr_t                    head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [DEPTH-1:0]           entry_valid,
    output ptr_wr_t [DEPTH-1:0]        entries
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    ptr_wr_t       mem [DEPTH];
    logic [AW-1:0] slot_ofs;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked solely by the
    // pointers, so stale slot contents are never observed as valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // A slot is live when its distance from the read pointer is below count.
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned (which would infer a latch).
    always_comb begin
        entry_valid = '0;
        entries     = '0;
        slot_ofs    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_ofs       = AW'(i) - rd_ptr[AW-1:0];
            entry_valid[i] = ({1'b0, slot_ofs} < count);
            entries[i]     = mem[i];
        end
    end

endmodule

// File: rtl/ptr_writeback_queue.sv
// ----------------------------------------------------------------------------
// ptr_writeback_queue
// Write-side front end of the pointer register file. Buffers pointer writes
// from execute, drains one per cycle onto the file's write port while staying
// clear of p0 reads (which share the p0/pw address port), and turns writes to
// PC_PREG into a jump pulse that also discards younger queued writes.
//   clk, reset                    : clock, asynchronous active-high reset
//   req_valid/req_ready           : enqueue handshake
//   req_p, req_lbid, req_ofs      : write being offered
//   rd0_next                      : a p0 read wants the port next cycle
//   chk_p / chk_hit               : RAW hazard probe for the decoder
//   we, pw, lbidw, ofsw           : register file write port (registered)
//   jump_valid/lbid/ofs           : jump pulse and target (registered)
//   pending                       : queue holds at least one write
// ----------------------------------------------------------------------------
module ptr_writeback_queue
    import ptr_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [PREG_AW-1:0]  req_p,
    input  logic [LBID_W-1:0]   req_lbid,
    input  logic [OFS_W-1:0]    req_ofs,
    input  logic                rd0_next,
    input  logic [PREG_AW-1:0]  chk_p,
    output logic                chk_hit,
    output logic                we,
    output logic [PREG_AW-1:0]  pw,
    output logic [LBID_W-1:0]   lbidw,
    output logic [OFS_W-1:0]    ofsw,
    output logic                jump_valid,
    output logic [LBID_W-1:0]   jump_lbid,
    output logic [OFS_W-1:0]    jump_ofs,
    output logic                pending
);

    localparam int             SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

    wbq_state_e                 state;
    logic [SW-1:0]              starve_cnt;

    ptr_wr_t                    push_data;
    ptr_wr_t                    head;
    logic [$clog2(DEPTH):0]     count;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [DEPTH-1:0]           entry_valid;
    ptr_wr_t [DEPTH-1:0]        entries;

    logic                       push;
    logic                       issue;
    logic                       issue_jump;

    assign push_data = '{p: req_p, lbid: req_lbid, ofs: req_ofs};

    // Ready depends only on pre-edge occupancy, so a same-edge pop never
    // lets a push into a full queue.
    assign req_ready = !fifo_full && (state == ST_RUN);
    assign push      = req_valid && req_ready;

    // Issuing at this edge puts we high during the cycle rd0_next describes,
    // so a wanted p0 read blocks issue unless the head has starved too long.
    assign issue      = (state == ST_RUN) && !fifo_empty &&
                        (!rd0_next || (starve_cnt == STARVE_MAX));
    assign issue_jump = issue && is_jump(head);

    assign pending = (count != '0);

    ptr_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_data   (push_data),
        .pop         (issue),
        // A jump discards everything younger, including a write accepted on
        // the same edge.
        .flush       (issue_jump),
        .head        (head),
        .count       (count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entries     (entries)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            starve_cnt <= '0;
            we         <= 1'b0;
            pw         <= '0;
            lbidw      <= '0;
            ofsw       <= '0;
            jump_valid <= 1'b0;
            jump_lbid  <= '0;
            jump_ofs   <= '0;
        end else begin
            we         <= issue;
            jump_valid <= issue_jump;

            // Write data holds between issues; only we qualifies it.
            if (issue) begin
                pw    <= head.p;
                lbidw <= head.lbid;
                ofsw  <= head.ofs;
            end

            if (issue_jump) begin
                jump_lbid <= head.lbid;
                jump_ofs  <= head.ofs;
            end

            // FLUSH is a single bubble: no accept, no issue.
            case (state)
                ST_RUN:   if (issue_jump) state <= ST_FLUSH;
                ST_FLUSH: state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase

            if (issue || fifo_empty) begin
                starve_cnt <= '0;
            end else if (rd0_next && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // The entry on the write port this cycle is still in flight for a reader.
    always_comb begin
        chk_hit = we && (pw == chk_p);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entries[i].p == chk_p)) chk_hit = 1'b1;
        end
    end

endmodule

// File: tb/tb_ptr_writeback_queue.sv
// ----------------------------------------------------------------------------
// tb_ptr_writeback_queue
// Directed bench: a vector table for single write, starvation and hazard
// behaviour, then hand-written sequences for backpressure, jump flush and
// asynchronous reset mid-drain.
// ----------------------------------------------------------------------------
module tb_ptr_writeback_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_p;
    logic [11:0] req_lbid;
    logic [15:0] req_ofs;
    logic        rd0_next;
    logic [5:0]  chk_p;
    logic        chk_hit;
    logic        we;
    logic [5:0]  pw;
    logic [11:0] lbidw;
    logic [15:0] ofsw;
    logic        jump_valid;
    logic [11:0] jump_lbid;
    logic [15:0] jump_ofs;
    logic        pending;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ptr_writeback_queue #(
        .DEPTH        (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_p      (req_p),
        .req_lbid   (req_lbid),
        .req_ofs    (req_ofs),
        .rd0_next   (rd0_next),
        .chk_p      (chk_p),
        .chk_hit    (chk_hit),
        .we         (we),
        .pw         (pw),
        .lbidw      (lbidw),
        .ofsw       (ofsw),
        .jump_valid (jump_valid),
        .jump_lbid  (jump_lbid),
        .jump_ofs   (jump_ofs),
        .pending    (pending)
    );

    typedef struct {
        logic        valid;
        logic [5:0]  p;
        logic [11:0] lbid;
        logic [15:0] ofs;
        logic        rd0;
        logic [5:0]  chk;
        logic        e_ready;
        logic        e_we;
        logic [5:0]  e_pw;
        logic [11:0] e_lbidw;
        logic [15:0] e_ofsw;
        logic        e_jv;
        logic        e_pending;
        logic        e_hit;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] p, input logic [11:0] l,
                         input logic [15:0] o, input logic rd0, input logic [5:0] c);
        req_valid = v;
        req_p     = p;
        req_lbid  = l;
        req_ofs   = o;
        rd0_next  = rd0;
        chk_p     = c;
    endtask

    initial begin
        // Inputs, then outputs observed in that cycle before the next edge.
        //          v  p      lbid     ofs       rd0 chk    rdy we pw     lbidw    ofsw      jv pnd hit
        vecs[0]  = '{0, 6'd0, 12'h000, 16'h0000, 0, 6'd5,  1, 0, 6'd0, 12'h000, 16'h0000, 0, 0, 0};
        vecs[1]  = '{1, 6'd5, 12'h012, 16'h1234, 0, 6'd5,  1, 0, 6'd0, 12'h000, 16'h0000, 0, 0, 0};
        vecs[2]  = '{0, 6'd0, 12'h000, 16'h0000, 0, 6'd5,  1, 0, 6'd0, 12'h000, 16'h0000, 0, 1, 1};
        vecs[3]  = '{0, 6'd0, 12'h000, 16'h0000, 0, 6'd5,  1, 1, 6'd5, 12'h012, 16'h1234, 0, 0, 1};
        vecs[4]  = '{0, 6'd0, 12'h000, 16'h0000, 0, 6'd5,  1, 0, 6'd5, 12'h012, 16'h1234, 0, 0, 0};
        vecs[5]  = '{1, 6'd9, 12'h0A1, 16'h00B2, 1, 6'd9,  1, 0, 6'd5, 12'h012, 16'h1234, 0, 0, 0};
        vecs[6]  = '{0, 6'd0, 12'h000, 16'h0000, 1, 6'd9,  1, 0, 6'd5, 12'h012, 16'h1234, 0, 1, 1};
        vecs[7]  = '{0, 6'd0, 12'h000, 16'h0000, 1, 6'd9,  1, 0, 6'd5, 12'h012, 16'h1234, 0, 1, 1};
        vecs[8]  = '{0, 6'd0, 12'h000, 16'h0000, 1, 6'd9,  1, 0, 6'd5, 12'h012, 16'h1234, 0, 1, 1};
        vecs[9]  = '{0, 6'd0, 12'h000, 16'h0000, 1, 6'd9,  1, 0, 6'd5, 12'h012, 16'h1234, 0, 1, 1};
        vecs[10] = '{0, 6'd0, 12'h000, 16'h0000, 1, 6'd9,  1, 1, 6'd9, 12'h0A1, 16'h00B2, 0, 0, 1};
        vecs[11] = '{0, 6'd0, 12'h000, 16'h0000, 1, 6'd9,  1, 0, 6'd9, 12'h0A1, 16'h00B2, 0, 0, 0};
        vecs[12] = '{1, 6'd9, 12'h003, 16'h0004, 0, 6'd10, 1, 0, 6'd9, 12'h0A1, 16'h00B2, 0, 0, 0};
        vecs[13] = '{0, 6'd0, 12'h000, 16'h0000, 0, 6'd10, 1, 0, 6'd9, 12'h0A1, 16'h00B2, 0, 1, 0};
        vecs[14] = '{0, 6'd0, 12'h000, 16'h0000, 0, 6'd10, 1, 1, 6'd9, 12'h003, 16'h0004, 0, 0, 0};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_we",        32'(we),         32'd0);
        check("rst_jump_valid", 32'(jump_valid), 32'd0);
        check("rst_jump_lbid", 32'(jump_lbid),  32'd0);
        check("rst_jump_ofs",  32'(jump_ofs),   32'd0);
        check("rst_pending",   32'(pending),    32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table: single write, starvation, hazard ----------
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].valid, vecs[i].p, vecs[i].lbid, vecs[i].ofs, vecs[i].rd0, vecs[i].chk);
            #1;
            check($sformatf("v%0d_ready", i),   32'(req_ready),  32'(vecs[i].e_ready));
            check($sformatf("v%0d_we", i),      32'(we),         32'(vecs[i].e_we));
            check($sformatf("v%0d_pw", i),      32'(pw),         32'(vecs[i].e_pw));
            check($sformatf("v%0d_lbidw", i),   32'(lbidw),      32'(vecs[i].e_lbidw));
            check($sformatf("v%0d_ofsw", i),    32'(ofsw),       32'(vecs[i].e_ofsw));
            check($sformatf("v%0d_jv", i),      32'(jump_valid), 32'(vecs[i].e_jv));
            check($sformatf("v%0d_pending", i), 32'(pending),    32'(vecs[i].e_pending));
            check($sformatf("v%0d_hit", i),     32'(chk_hit),    32'(vecs[i].e_hit));
            @(negedge clk);
        end

        // ---------------- full / backpressure, FIFO-order drain ------------
        for (int k = 1; k <= 4; k++) begin
            drive(1, 6'(k), 12'(12'h100 + k), 16'(16'h1000 + k), 1, 6'd0);
            #1;
            check($sformatf("fill%0d_ready", k), 32'(req_ready), 32'd1);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 6'd0);
        #1;
        check("full_ready",   32'(req_ready), 32'd0);
        check("full_pending", 32'(pending),   32'd1);
        check("full_we",      32'(we),        32'd0);
        @(negedge clk);
        // First drain cycle: room for one; push lands together with the next pop.
        drive(1, 6'd5, 12'h105, 16'h1005, 0, 6'd0);
        #1;
        check("drain1_we",    32'(we),        32'd1);
        check("drain1_pw",    32'(pw),        32'd1);
        check("drain1_lbidw", 32'(lbidw),     32'h101);
        check("drain1_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 6'd0);
        for (int k = 2; k <= 5; k++) begin
            #1;
            check($sformatf("drain%0d_we", k),      32'(we),      32'd1);
            check($sformatf("drain%0d_pw", k),      32'(pw),      32'(k));
            check($sformatf("drain%0d_lbidw", k),   32'(lbidw),   32'(12'h100 + k));
            check($sformatf("drain%0d_ofsw", k),    32'(ofsw),    32'(16'h1000 + k));
            check($sformatf("drain%0d_pending", k), 32'(pending), (k == 5) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        #1;
        check("drain_done_we", 32'(we), 32'd0);
        @(negedge clk);

        // ---------------- jump flush ----------------------------------------
        drive(1, 6'h3F, 12'h007, 16'h0040, 1, 6'd0);
        @(negedge clk);
        drive(1, 6'd2, 12'h222, 16'h2222, 1, 6'd0);
        @(negedge clk);
        drive(1, 6'd4, 12'h444, 16'h4444, 1, 6'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 6'd0);
        #1;
        check("jmp_pre_jv",      32'(jump_valid), 32'd0);
        check("jmp_pre_pending", 32'(pending),    32'd1);
        @(negedge clk);
        // Offer a write during the bubble; it must be refused.
        drive(1, 6'd6, 12'h666, 16'h6666, 0, 6'd0);
        #1;
        check("jmp_we",      32'(we),         32'd1);
        check("jmp_pw",      32'(pw),         32'h3F);
        check("jmp_jv",      32'(jump_valid), 32'd1);
        check("jmp_lbid",    32'(jump_lbid),  32'h007);
        check("jmp_ofs",     32'(jump_ofs),   32'h0040);
        check("jmp_ready",   32'(req_ready),  32'd0);
        check("jmp_pending", 32'(pending),    32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 6'd0);
        #1;
        check("jmp_post_jv",    32'(jump_valid), 32'd0);
        check("jmp_post_ready", 32'(req_ready),  32'd1);
        check("jmp_hold_lbid",  32'(jump_lbid),  32'h007);
        check("jmp_hold_ofs",   32'(jump_ofs),   32'h0040);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("jmp_flushed%0d_we", k),      32'(we),      32'd0);
            check($sformatf("jmp_flushed%0d_pending", k), 32'(pending), 32'd0);
            @(negedge clk);
        end

        // ---------------- asynchronous reset mid-drain ---------------------
        for (int k = 1; k <= 4; k++) begin
            drive(1, 6'(16 + k), 12'(12'h300 + k), 16'(16'h3000 + k), 1, 6'd0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 6'd0);
        @(negedge clk);
        #1;
        check("rstmid_pre_we",      32'(we),      32'd1);
        check("rstmid_pre_pw",      32'(pw),      32'd17);
        check("rstmid_pre_pending", 32'(pending), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_we",      32'(we),         32'd0);
        check("rstmid_jv",      32'(jump_valid), 32'd0);
        check("rstmid_pending", 32'(pending),    32'd0);
        check("rstmid_pw",      32'(pw),         32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rstmid_after%0d_we", k),      32'(we),      32'd0);
            check($sformatf("rstmid_after%0d_pending", k), 32'(pending), 32'd0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
